// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg
// Definitions shared by the sequential multiplier, its product collector
// and any future issuer: the collector state encoding and width helpers.
// No ports; import with `import seq_mult_pkg::*;`.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } collect_state_e;

    // Chunk counter width: holds 0 .. 2*max_width/p inclusive.
    function automatic int chunk_cnt_w(input int max_width, input int p);
        return $clog2(2 * max_width / p) + 1;
    endfunction

    // Full product width for a given maximum operand width.
    function automatic int prod_w(input int max_width);
        return 2 * max_width;
    endfunction

    localparam int DEF_P         = 2;
    localparam int DEF_MAX_WIDTH = 16;
    localparam int DEF_CNT_W     = chunk_cnt_w(DEF_MAX_WIDTH, DEF_P);
    localparam int DEF_PROD_W    = prod_w(DEF_MAX_WIDTH);

endpackage

// File: rtl/chunk_counter.sv
// chunk_counter
// Loadable saturating up-counter with a sticky overflow flag. Counting
// stops at MAX; every enable seen while saturated sets ovf until the next
// clear, load or reset. Priority: clr > load > en.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   clr               zero the count and the overflow flag
//   load, load_val    load an arbitrary count (also clears ovf)
//   en                count one event
//   count             current count
//   sat               count has reached MAX
//   ovf               an event arrived while saturated (sticky)
module chunk_counter
    import seq_mult_pkg::*;
#(
    parameter int W   = DEF_CNT_W,
    parameter int MAX = DEF_PROD_W / DEF_P
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         sat,
    output logic         ovf
);

    assign sat = (count >= W'(MAX));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (load) begin
            count <= load_val;
            ovf   <= 1'b0;
        end else if (en) begin
            if (sat) begin
                ovf <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_mult_collector.sv
// seq_mult_collector
// Receives the P-bit product chunks streamed by seq_mult (LSB chunk first,
// strobed by newOut), reassembles the full 2*MAX_WIDTH product and offers
// it downstream on a valid/ready handshake. busy back-pressures the issuer
// from the cycle after start until the product has been taken.
//
// Optional build macro:
//   SEQ_MULT_COLLECTOR_SIGNEXT_EN  when defined, prod bits above 2*bitsize
//                                  copy bit 2*bitsize-1 (two's-complement
//                                  product); otherwise they are zero.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   start         arms the collector (ignored in HOLD)
//   bitsize       operand width, sampled with start
//   p, newOut     product chunk and its strobe
//   done          multiplier completion pulse
//   prod          assembled product, held while prod_valid
//   prod_valid    prod/err are valid
//   prod_ready    downstream accept
//   err           chunk count differed from 2*bitsize/P, or overflow
//   busy          high while collecting or holding a result
module seq_mult_collector
    import seq_mult_pkg::*;
#(
    parameter int P         = 2,
    parameter int MAX_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [$clog2(MAX_WIDTH)-1:0] bitsize,
    input  logic [P-1:0]                 p,
    input  logic                         newOut,
    input  logic                         done,
    output logic [2*MAX_WIDTH-1:0]       prod,
    output logic                         prod_valid,
    input  logic                         prod_ready,
    output logic                         err,
    output logic                         busy
);

    localparam int PW      = prod_w(MAX_WIDTH);
    localparam int BS_W    = $clog2(MAX_WIDTH);
    localparam int CNT_MAX = PW / P;
    localparam int CNT_W   = chunk_cnt_w(MAX_WIDTH, P);

    collect_state_e   state;
    logic [PW-1:0]    sr;
    logic [PW-1:0]    sr_ins;
    logic [PW-1:0]    prod_fill;
    logic [BS_W-1:0]  bs_q;
    logic [CNT_W-1:0] k;
    logic             k_sat;
    logic             k_ovf;
    logic             chunk_ok;
    logic             cnt_clr;
    logic             cnt_en;
    logic             err_next;
    int               k_final;
    int               n_exp;

    // Bits at and above 2*bs are replaced by the fill bit: zero, or the
    // product's sign bit when sign extension is compiled in.
    function automatic logic [PW-1:0] fill_upper(input logic [PW-1:0]   v,
                                                 input logic [BS_W-1:0] bs);
        logic [PW-1:0] r;
        int            lim;
        logic          s;
        lim = 2 * int'(bs);
        s   = 1'b0;
`ifdef SEQ_MULT_COLLECTOR_SIGNEXT_EN
        for (int i = 0; i < PW; i++) begin
            if (i == lim - 1) s = v[i];
        end
`endif
        r = v;
        for (int i = 0; i < PW; i++) begin
            if (i >= lim) r[i] = s;
        end
        return r;
    endfunction

    // start re-arms from IDLE or COLLECT; in HOLD it must not disturb the
    // held result. A chunk coincident with an aborting start is discarded.
    assign cnt_clr = start && (state != HOLD);
    assign cnt_en  = (state == COLLECT) && newOut && !start;

    chunk_counter #(
        .W   (CNT_W),
        .MAX (CNT_MAX)
    ) u_chunk_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .load     (1'b0),
        .load_val ('0),
        .en       (cnt_en),
        .count    (k),
        .sat      (k_sat),
        .ovf      (k_ovf)
    );

    // Shift register with this cycle's chunk already inserted, so a chunk
    // arriving together with done lands in the result and in the count.
    always_comb begin
        sr_ins   = sr;
        chunk_ok = newOut && !k_sat;
        if (chunk_ok) begin
            for (int i = 0; i < CNT_MAX; i++) begin
                if (k == CNT_W'(i)) sr_ins[i*P +: P] = p;
            end
        end
        k_final  = int'(k) + (chunk_ok ? 1 : 0);
        n_exp    = (2 * int'(bs_q)) / P;
        err_next = (k_final != n_exp) || k_ovf || (newOut && k_sat);
    end

    assign prod_fill = fill_upper(sr_ins, bs_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            sr         <= '0;
            bs_q       <= '0;
            prod       <= '0;
            prod_valid <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sr    <= '0;
                        bs_q  <= bitsize;
                        state <= COLLECT;
                        busy  <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (start) begin
                        sr   <= '0;
                        bs_q <= bitsize;
                    end else begin
                        sr <= sr_ins;
                        if (done) begin
                            state      <= HOLD;
                            prod       <= prod_fill;
                            err        <= err_next;
                            prod_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (prod_ready) begin
                        state      <= IDLE;
                        prod_valid <= 1'b0;
                        err        <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_collector.sv
module tb_seq_mult_collector;

`ifdef SEQ_MULT_COLLECTOR_SIGNEXT_EN
    localparam bit SE = 1'b1;
`else
    localparam bit SE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  bitsize;
    logic [1:0]  p;
    logic        newOut;
    logic        done;
    logic [31:0] prod;
    logic        prod_valid;
    logic        prod_ready;
    logic        err;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    seq_mult_collector #(.P(2), .MAX_WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bitsize    (bitsize),
        .p          (p),
        .newOut     (newOut),
        .done       (done),
        .prod       (prod),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .err        (err),
        .busy       (busy)
    );

    typedef struct {
        logic [3:0]  bs;
        int          n;
        logic [63:0] chunks;
        logic        coinc;
        logic [31:0] exp_prod;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    // One full transaction: start, chunks, done, optional HOLD stall with a
    // stray start/newOut/done in it, then the handshake.
    task automatic run_txn(input vec_t v, input int stall, input string tag);
        start   = 1'b1;
        bitsize = v.bs;
        tick();
        start = 1'b0;
        chk({tag, "_busy_start"}, 64'(busy), 64'd1);
        chk({tag, "_pv_start"}, 64'(prod_valid), 64'd0);
        for (int i = 0; i < v.n; i++) begin
            newOut = 1'b1;
            p      = 2'(v.chunks >> (2 * i));
            done   = v.coinc && (i == v.n - 1);
            tick();
            newOut = 1'b0;
            done   = 1'b0;
        end
        if (!v.coinc) begin
            chk({tag, "_pv_pre_done"}, 64'(prod_valid), 64'd0);
            done = 1'b1;
            tick();
            done = 1'b0;
        end
        chk({tag, "_pv"}, 64'(prod_valid), 64'd1);
        chk({tag, "_prod"}, 64'(prod), 64'(v.exp_prod));
        chk({tag, "_err"}, 64'(err), 64'(v.exp_err));
        chk({tag, "_busy_hold"}, 64'(busy), 64'd1);
        for (int s = 0; s < stall; s++) begin
            if (s == 2) begin
                start   = 1'b1;
                bitsize = 4'd8;
                newOut  = 1'b1;
                p       = 2'b11;
                done    = 1'b1;
            end
            tick();
            start  = 1'b0;
            newOut = 1'b0;
            done   = 1'b0;
            chk($sformatf("%s_stall%0d_pv", tag, s), 64'(prod_valid), 64'd1);
            chk($sformatf("%s_stall%0d_prod", tag, s), 64'(prod), 64'(v.exp_prod));
            chk($sformatf("%s_stall%0d_err", tag, s), 64'(err), 64'(v.exp_err));
            chk($sformatf("%s_stall%0d_busy", tag, s), 64'(busy), 64'd1);
        end
        prod_ready = 1'b1;
        tick();
        prod_ready = 1'b0;
        chk({tag, "_pv_after_hs"}, 64'(prod_valid), 64'd0);
        chk({tag, "_busy_after_hs"}, 64'(busy), 64'd0);
    endtask

    initial begin
        vecs[0] = '{4'd4,  4,  64'h36,         1'b0, 32'h0000_0036, 1'b0};
        vecs[1] = '{4'd4,  4,  64'hFF,         1'b0, SE ? 32'hFFFF_FFFF : 32'h0000_00FF, 1'b0};
        vecs[2] = '{4'd4,  3,  64'h36,         1'b0, 32'h0000_0036, 1'b1};
        vecs[3] = '{4'd4,  4,  64'hC9,         1'b1, SE ? 32'hFFFF_FFC9 : 32'h0000_00C9, 1'b0};
        vecs[4] = '{4'd8,  8,  64'h1234,       1'b0, 32'h0000_1234, 1'b0};
        vecs[5] = '{4'd2,  2,  64'h5,          1'b0, 32'h0000_0005, 1'b0};
        vecs[6] = '{4'd4,  5,  64'h136,        1'b0, 32'h0000_0036, 1'b1};
        vecs[7] = '{4'd14, 17, 64'h3_0ABC_DEF1, 1'b0, SE ? 32'hFABC_DEF1 : 32'h0ABC_DEF1, 1'b1};

        rst_n      = 1'b0;
        start      = 1'b0;
        bitsize    = 4'd0;
        p          = 2'b00;
        newOut     = 1'b0;
        done       = 1'b0;
        prod_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_prod", 64'(prod), 64'd0);
        chk("rst_pv", 64'(prod_valid), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        // Back-to-back transactions: each start lands the cycle after the
        // previous handshake.
        for (int i = 0; i < 8; i++)
            run_txn(vecs[i], 0, $sformatf("vec%0d", i));

        // Held result under back-pressure, with a stray start in HOLD.
        run_txn(vecs[3], 5, "stall");
        run_txn(vecs[0], 0, "after_stall");

        // Reset in the middle of a collection.
        start   = 1'b1;
        bitsize = 4'd4;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            newOut = 1'b1;
            p      = 2'b11;
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n  = 1'b1;
        newOut = 1'b0;
        chk("midrst_prod", 64'(prod), 64'd0);
        chk("midrst_pv", 64'(prod_valid), 64'd0);
        chk("midrst_err", 64'(err), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            newOut = 1'b1;
            p      = 2'b11;
            done   = (i == 2);
            tick();
        end
        newOut = 1'b0;
        done   = 1'b0;
        tick();
        chk("postrst_pv", 64'(prod_valid), 64'd0);
        chk("postrst_busy", 64'(busy), 64'd0);
        chk("postrst_prod", 64'(prod), 64'd0);
        run_txn(vecs[1], 0, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
